bht_update_ctrl: RTL and testbench
==================================

# bht_update_ctrl

Update scheduler for the branch history table in the fetch stage. It accepts branch-resolution results from two execute lanes in the same cycle and buffers them in a small in-order FIFO. It drains them one per cycle onto the BHT's single write port (we / pc / branched). It also runs a post-reset index sweep and reports whether the current fetch PC's BHT index has an update still in flight.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥ 2)
- BHT_BIT, 5, BHT index width; the index is pc[BHT_BIT+1:2]
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  lane-0 (older) branch resolved this cycle
- req0_pc  in  32  lane-0 branch PC
- req0_taken  in  1  lane-0 outcome
- req1_valid  in  1  lane-1 (younger) branch resolved this cycle
- req1_pc  in  32  lane-1 branch PC
- req1_taken  in  1  lane-1 outcome
- req_ready  out  1  both lanes may present a request this cycle
- if1_pc  in  32  current fetch PC, used for the pending-hit check
- bht_we  out  1  BHT write enable
- bht_pc  out  32  PC of the entry being written
- bht_branched  out  1  outcome of the entry being written
- pend_hit  out  1  a queued entry has the same index as if1_pc
- init_busy  out  1  post-reset sweep in progress
- init_idx  out  BHT_BIT  sweep index

## Operation
- FSM states:
  - INIT is entered on any cycle with rst_n=0.
  - INIT → RUN after init_idx reaches 2^BHT_BIT−1.
  - RUN has no exit except reset.
- INIT:
  - init_busy=1.
  - init_idx increments by 1 per cycle, starting at 0.
  - req_ready=0; bht_we=0; pend_hit=0.
  - req*_valid is ignored.
- RUN:
  - init_busy=0; init_idx holds 0.
- Push:
  - When req_ready=1, each valid lane is written at the tail, lane 0 first.
  - 0, 1 or 2 entries are pushed per cycle.
  - req1 alone is legal and pushes 1 entry.
  - When req_ready=0, requests are dropped. Upstream must not present them.
- req_ready = RUN && (DEPTH − count ≥ 2).
  - count is the registered occupancy at the start of the cycle, before that cycle's pop.
- Pop:
  - In RUN with count>0: bht_we=1, and bht_pc/bht_branched are the head entry, driven combinationally from registered FIFO storage.
  - The head is removed at the clock edge.
  - Exactly one pop per cycle whenever non-empty.
  - With count=0, bht_we=0 and bht_pc/bht_branched=0.
- Occupancy: count_next = count + pushes − pop. count is DEPTH-bounded and cannot overflow, because pushes only occur when ≥2 slots are free.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Order: BHT writes occur in strict acceptance order. Lane 0 precedes lane 1 within a cycle.
- pend_hit (combinational, RUN only) = OR over valid entries of (entry_pc[BHT_BIT+1:2] == if1_pc[BHT_BIT+1:2]).
  - The head entry is included in the compare, including on the cycle it is being written.
  - Same-cycle incoming requests are excluded.

## Timing
- Reset values (rst_n=0 at an edge): count=0, head=tail=0, state=INIT, init_idx=0.
  - Outputs the next cycle: init_busy=1, req_ready=0, bht_we=0, bht_pc=0, bht_branched=0, pend_hit=0.
- The sweep lasts exactly 2^BHT_BIT cycles. init_busy falls and req_ready rises on cycle 2^BHT_BIT after reset release (cycle 32 for the default).
- Latency:
  - A request accepted at edge N with an empty FIFO appears on bht_we in cycle N+1.
  - The second lane of a dual push appears in cycle N+2.
- Reset asserted mid-operation discards all queued entries with no further writes, and restarts INIT.
- Steady dual issue fills the FIFO by 1 per cycle. req_ready deasserts once count ≥ DEPTH−1.

## Test plan
- Reset sweep:
  - Stimulus: hold rst_n=0 for 2 cycles, then release.
  - Required: init_idx steps 0..31 over 32 cycles with init_busy=1, then init_busy=0, req_ready=1.
  - Required: requests presented during INIT never cause a write.
- Single request:
  - Stimulus: req0 pc=0x1C00_0010 taken=1 in RUN.
  - Required: the next cycle shows bht_we=1, bht_pc=0x1C00_0010, bht_branched=1; the cycle after shows bht_we=0.
- Dual ordering:
  - Stimulus: req0 pc=0x100 taken=0 and req1 pc=0x104 taken=1 in the same cycle.
  - Required: the next two cycles write 0x100/0 then 0x104/1.
- Backpressure:
  - Stimulus: dual requests on 3 consecutive cycles with DEPTH=4.
  - Required: count goes 2, 3. req_ready=0 at count=3. Writes continue in order. req_ready returns at count=2.
- pend_hit:
  - Stimulus: queue pc=0x1C (index 7); drive if1_pc=0x9C (index 7), then 0x20.
  - Required: pend_hit=1, then 0.
  - Required: pend_hit=0 once the entry has been written.
- Mid-op reset:
  - Stimulus: fill with 3 entries, then assert rst_n=0.
  - Required: no bht_we after reset, init_idx restarts at 0, and the FIFO is empty after INIT.

Source files
------------

// File: rtl/bht_update_ctrl.sv
// Purpose : Merges dual-lane branch resolutions into an in-order FIFO and drains
//           them one per cycle onto the BHT write port. After reset it sweeps
//           every BHT index, and it flags when the fetch PC's index is still queued.
// Latency : a request pushed into an empty FIFO is written 1 cycle later; the
//           second lane of a dual push is written 2 cycles later.
// Backpressure: req_ready stays high only while at least two slots are free, so
//           a dual push always fits. Requests seen while req_ready=0 are dropped.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req0_* / req1_*               branch results from the older / younger lane
//   req_ready                     both lanes may present this cycle
//   if1_pc                        fetch PC for the pending-update check
//   bht_we, bht_pc, bht_branched  BHT write port (head of FIFO)
//   pend_hit                      a queued entry matches if1_pc's index
//   init_busy, init_idx           post-reset sweep status and index
module bht_update_ctrl #(
    parameter int DEPTH   = 4,
    parameter int BHT_BIT = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [31:0]        req0_pc,
    input  logic               req0_taken,
    input  logic               req1_valid,
    input  logic [31:0]        req1_pc,
    input  logic               req1_taken,
    output logic               req_ready,
    input  logic [31:0]        if1_pc,
    output logic               bht_we,
    output logic [31:0]        bht_pc,
    output logic               bht_branched,
    output logic               pend_hit,
    output logic               init_busy,
    output logic [BHT_BIT-1:0] init_idx
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BHT_BIT-1:0] init_idx_q, init_idx_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        pc_mem_q [DEPTH];
    logic [31:0]        pc_mem_d [DEPTH];
    logic               tk_mem_q [DEPTH];
    logic               tk_mem_d [DEPTH];

    logic               pop;
    logic [1:0]         n_push;
    logic [PTR_W-1:0]   wr_ptr;

    // Only the index bits of the fetch PC take part in the pending check.
    logic unused_if1_bits;
    assign unused_if1_bits = ^{if1_pc[31:BHT_BIT+2], if1_pc[1:0]};

    assign init_idx = init_idx_q;

    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        pc_mem_d     = pc_mem_q;
        tk_mem_d     = tk_mem_q;
        pop          = 1'b0;
        n_push       = 2'd0;
        wr_ptr       = tail_q;
        init_busy    = 1'b0;
        req_ready    = 1'b0;
        bht_we       = 1'b0;
        bht_pc       = 32'd0;
        bht_branched = 1'b0;
        pend_hit     = 1'b0;

        case (state_q)
            ST_INIT: begin
                init_busy = 1'b1;
                if (init_idx_q == {BHT_BIT{1'b1}}) begin
                    state_d    = ST_RUN;
                    init_idx_d = '0;
                end else begin
                    init_idx_d = init_idx_q + 1'b1;
                end
            end

            ST_RUN: begin
                // Uses occupancy before this cycle's pop, so the pop never
                // has to be relied on to make room for a dual push.
                req_ready = (count_q <= CNT_W'(DEPTH - 2));
                pop       = (count_q != '0);

                bht_we = pop;
                if (pop) begin
                    bht_pc       = pc_mem_q[head_q];
                    bht_branched = tk_mem_q[head_q];
                end

                // Lane 0 lands first so the BHT sees updates in program order.
                if (req_ready && req0_valid) begin
                    pc_mem_d[wr_ptr] = req0_pc;
                    tk_mem_d[wr_ptr] = req0_taken;
                    wr_ptr           = wr_ptr + 1'b1;
                    n_push           = n_push + 2'd1;
                end
                if (req_ready && req1_valid) begin
                    pc_mem_d[wr_ptr] = req1_pc;
                    tk_mem_d[wr_ptr] = req1_taken;
                    wr_ptr           = wr_ptr + 1'b1;
                    n_push           = n_push + 2'd1;
                end

                tail_d  = wr_ptr;
                head_d  = head_q + PTR_W'(pop);
                count_d = count_q + CNT_W'(n_push) - CNT_W'(pop);

                // An entry is live when its distance from head is below count;
                // the head is included even on the cycle it is being written.
                for (int i = 0; i < DEPTH; i++) begin
                    if ((CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q) &&
                        (pc_mem_q[i][BHT_BIT+1:2] == if1_pc[BHT_BIT+1:2])) begin
                        pend_hit = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset: it is only observed through count.
    always_ff @(posedge clk) begin
        pc_mem_q <= pc_mem_d;
        tk_mem_q <= tk_mem_d;
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
module tb_bht_update_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [31:0] req0_pc;
    logic        req0_taken;
    logic        req1_valid;
    logic [31:0] req1_pc;
    logic        req1_taken;
    logic        req_ready;
    logic [31:0] if1_pc;
    logic        bht_we;
    logic [31:0] bht_pc;
    logic        bht_branched;
    logic        pend_hit;
    logic        init_busy;
    logic [4:0]  init_idx;

    int checks = 0;
    int errors = 0;

    // Record of every BHT write, sampled mid-cycle.
    logic [32:0] wq[$];

    bht_update_ctrl #(.DEPTH(4), .BHT_BIT(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_pc      (req0_pc),
        .req0_taken   (req0_taken),
        .req1_valid   (req1_valid),
        .req1_pc      (req1_pc),
        .req1_taken   (req1_taken),
        .req_ready    (req_ready),
        .if1_pc       (if1_pc),
        .bht_we       (bht_we),
        .bht_pc       (bht_pc),
        .bht_branched (bht_branched),
        .pend_hit     (pend_hit),
        .init_busy    (init_busy),
        .init_idx     (init_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bht_we === 1'b1) wq.push_back({bht_pc, bht_branched});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req0_valid = 1'b0; req0_pc = 32'd0; req0_taken = 1'b0;
        req1_valid = 1'b0; req1_pc = 32'd0; req1_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (init_busy !== 1'b1 || req_ready !== 1'b0 || bht_we !== 1'b0 ||
                bht_pc !== 32'd0 || bht_branched !== 1'b0 || pend_hit !== 1'b0 ||
                init_idx !== 5'd0) begin
                errors++;
                $display("FAIL reset_outputs: busy=%b rdy=%b we=%b pc=%h br=%b hit=%b idx=%0d required 1 0 0 0 0 0 0",
                         init_busy, req_ready, bht_we, bht_pc, bht_branched, pend_hit, init_idx);
            end
        end
        // Requests during the sweep must be ignored.
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_pc = 32'h0000_0040; req0_taken = 1'b1;
        req1_valid = 1'b1; req1_pc = 32'h0000_0044; req1_taken = 1'b1;
        for (int k = 1; k < 32; k++) begin
            step();
            checks++;
            if (init_idx !== 5'(k) || init_busy !== 1'b1 || bht_we !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL sweep_step: idx=%0d busy=%b we=%b rdy=%b required idx=%0d busy=1 we=0 rdy=0",
                         init_idx, init_busy, bht_we, req_ready, k);
            end
        end
        clear_reqs();
        step();
        checks++;
        if (init_busy !== 1'b0 || req_ready !== 1'b1 || init_idx !== 5'd0 || bht_we !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done: busy=%b rdy=%b idx=%0d we=%b required 0 1 0 0",
                     init_busy, req_ready, init_idx, bht_we);
        end
        checks++;
        if (wq.size() !== 0) begin
            errors++;
            $display("FAIL init_no_write: writes=%0d required 0", wq.size());
        end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_pc = 32'h1C00_0010; req0_taken = 1'b1;
        step();
        clear_reqs();
        checks++;
        if (bht_we !== 1'b1 || bht_pc !== 32'h1C00_0010 || bht_branched !== 1'b1) begin
            errors++;
            $display("FAIL single_write: we=%b pc=%h br=%b required 1 1c000010 1", bht_we, bht_pc, bht_branched);
        end
        step();
        checks++;
        if (bht_we !== 1'b0 || bht_pc !== 32'd0) begin
            errors++;
            $display("FAIL single_drained: we=%b pc=%h required 0 0", bht_we, bht_pc);
        end
    endtask

    task automatic test_dual();
        req0_valid = 1'b1; req0_pc = 32'h0000_0100; req0_taken = 1'b0;
        req1_valid = 1'b1; req1_pc = 32'h0000_0104; req1_taken = 1'b1;
        step();
        clear_reqs();
        checks++;
        if (bht_we !== 1'b1 || bht_pc !== 32'h0000_0100 || bht_branched !== 1'b0) begin
            errors++;
            $display("FAIL dual_first: we=%b pc=%h br=%b required 1 00000100 0", bht_we, bht_pc, bht_branched);
        end
        step();
        checks++;
        if (bht_we !== 1'b1 || bht_pc !== 32'h0000_0104 || bht_branched !== 1'b1) begin
            errors++;
            $display("FAIL dual_second: we=%b pc=%h br=%b required 1 00000104 1", bht_we, bht_pc, bht_branched);
        end
        step();
        checks++;
        if (bht_we !== 1'b0) begin
            errors++;
            $display("FAIL dual_drained: we=%b required 0", bht_we);
        end
        // Lane 1 alone pushes one entry.
        req1_valid = 1'b1; req1_pc = 32'h0000_0108; req1_taken = 1'b1;
        step();
        clear_reqs();
        checks++;
        if (bht_we !== 1'b1 || bht_pc !== 32'h0000_0108 || bht_branched !== 1'b1) begin
            errors++;
            $display("FAIL lane1_only: we=%b pc=%h br=%b required 1 00000108 1", bht_we, bht_pc, bht_branched);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc[6];
        logic        exp_rdy[6];
        exp_pc  = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214};
        // count after each edge: 2,3,2,3,2,1 -> ready 1,0,1,0,1,1
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 6; c++) begin
            clear_reqs();
            // Dual issue on cycles 0, 1 and 3 (cycle 2 starts at count 3).
            if (c == 0 || c == 1 || c == 3) begin
                req0_valid = 1'b1; req0_pc = 32'h200 + 32'(8 * (c == 3 ? 2 : c)); req0_taken = 1'b0;
                req1_valid = 1'b1; req1_pc = req0_pc + 32'd4;                    req1_taken = 1'b1;
            end
            step();
            checks++;
            if (bht_we !== 1'b1 || bht_pc !== exp_pc[c] || req_ready !== exp_rdy[c]) begin
                errors++;
                $display("FAIL backpressure_c%0d: we=%b pc=%h rdy=%b required 1 %h %b",
                         c, bht_we, bht_pc, req_ready, exp_pc[c], exp_rdy[c]);
            end
        end
        clear_reqs();
        step();
        checks++;
        if (bht_we !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_drained: we=%b rdy=%b required 0 1", bht_we, req_ready);
        end
    endtask

    task automatic test_pend_hit();
        if1_pc = 32'h0000_009C;
        req0_valid = 1'b1; req0_pc = 32'h0000_0300; req0_taken = 1'b0;
        req1_valid = 1'b1; req1_pc = 32'h0000_001C; req1_taken = 1'b1;
        #1;
        checks++;
        if (pend_hit !== 1'b0) begin
            errors++;
            $display("FAIL pend_incoming_excluded: hit=%b required 0", pend_hit);
        end
        step();
        clear_reqs();
        checks++;
        if (pend_hit !== 1'b1) begin
            errors++;
            $display("FAIL pend_nonhead_hit: hit=%b required 1", pend_hit);
        end
        if1_pc = 32'h0000_0020;
        #1;
        checks++;
        if (pend_hit !== 1'b0) begin
            errors++;
            $display("FAIL pend_other_index: hit=%b required 0", pend_hit);
        end
        if1_pc = 32'h0000_009C;
        step();
        checks++;
        if (pend_hit !== 1'b1 || bht_pc !== 32'h0000_001C) begin
            errors++;
            $display("FAIL pend_head_hit: hit=%b pc=%h required 1 0000001c", pend_hit, bht_pc);
        end
        step();
        checks++;
        if (pend_hit !== 1'b0) begin
            errors++;
            $display("FAIL pend_after_write: hit=%b required 0", pend_hit);
        end
        if1_pc = 32'd0;
    endtask

    task automatic test_midreset();
        int n_before;
        req0_valid = 1'b1; req0_pc = 32'h400; req0_taken = 1'b1;
        req1_valid = 1'b1; req1_pc = 32'h404; req1_taken = 1'b0;
        step();
        req0_pc = 32'h408; req1_pc = 32'h40C;
        step();
        clear_reqs();
        // count is now 3
        checks++;
        if (req_ready !== 1'b0 || bht_pc !== 32'h404) begin
            errors++;
            $display("FAIL midreset_fill: rdy=%b pc=%h required 0 00000404", req_ready, bht_pc);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_before = wq.size();
        checks++;
        if (bht_we !== 1'b0 || init_busy !== 1'b1 || init_idx !== 5'd0) begin
            errors++;
            $display("FAIL midreset_restart: we=%b busy=%b idx=%0d required 0 1 0", bht_we, init_busy, init_idx);
        end
        for (int k = 0; k < 32; k++) step();
        checks++;
        if (init_busy !== 1'b0 || req_ready !== 1'b1 || bht_we !== 1'b0 || wq.size() !== n_before) begin
            errors++;
            $display("FAIL midreset_empty: busy=%b rdy=%b we=%b new_writes=%0d required 0 1 0 0",
                     init_busy, req_ready, bht_we, wq.size() - n_before);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        if1_pc = 32'd0;
        clear_reqs();
        test_reset();
        test_single();
        test_dual();
        test_backpressure();
        test_pend_hit();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
